// File: rtl/hamming_enc_scheduler.sv
// rtl/hamming_enc_scheduler.sv - round-robin shared Hamming(21,16) encode stage
module hamming_enc_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic [20:0]             out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        enc_count
);

  // Positional Hamming code: data fills the non-power-of-two positions,
  // parity at 2^k-1 covers every position i whose (i+1) has bit k set.
  function automatic logic [20:0] enc(input logic [15:0] d);
    logic [20:0] c;
    c        = '0;
    c[2]     = d[0];
    c[6:4]   = d[3:1];
    c[14:8]  = d[10:4];
    c[20:16] = d[15:11];
    c[0]     = ^(c & 21'h155555);
    c[1]     = ^(c & 21'h066666);
    c[3]     = ^(c & 21'h187878);
    c[7]     = ^(c & 21'h007F80);
    c[15]    = ^(c & 21'h1F8000);
    return c;
  endfunction

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            can_acc;
  logic            xin;
  logic            xout;
  logic [15:0]     word;

  // Stage is free when empty or when its current word leaves this cycle.
  assign can_acc = !out_valid || out_ready;
  assign xout    = out_valid && out_ready;
  assign xin     = |(req_ready & req_valid);
  assign word    = req_data[int'(win)*16 +: 16];

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      idx = ID_W'((int'(rr_ptr) + o) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Grant only the winner, and only when the stage can take a word.
  always_comb begin
    req_ready = '0;
    if (found && can_acc && !rst) begin
      req_ready[win] = 1'b1;
    end
  end

  // Output register, round-robin pointer and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      enc_count <= '0;
    end else begin
      if (xin) begin
        out_data  <= enc(word);
        out_id    <= win;
        out_valid <= 1'b1;
        rr_ptr    <= win;
      end else if (xout) begin
        out_valid <= 1'b0;
      end
      if (xout) begin
        enc_count <= enc_count + CNT_W'(1);
      end
    end
  end

endmodule
